// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state type,
// read-owner encoding and the default starvation-guard tuning.
package dmem_arb_pkg;

  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned DEF_STARVE_LIMIT = 8;
  localparam int unsigned DEF_FORCE_LEN    = 2;

endpackage

// File: rtl/dmem_arb_guard.sv
// Starvation guard for dmem_arbiter: starve/force counters and the ARB_CPU /
// ARB_FORCE FSM. Exists only when DMEM_ARB_STARVE_GUARD_EN is defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_guard
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned FORCE_LEN    = DEF_FORCE_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic dma_gnt,
  output logic force_win,
  output logic state
);

  localparam logic S_CPU   = 1'b0;
  localparam logic S_FORCE = 1'b1;

  logic       r_state;
  logic [7:0] r_starve;
  logic [7:0] w_starve_nxt;
  logic [3:0] r_force;
  logic [3:0] w_force_nxt;

  // A grant in the same cycle the limit would be reached clears the count,
  // so the window is only entered on a genuinely denied cycle.
  always_comb begin
    w_starve_nxt = r_starve;
    if (dma_gnt)
      w_starve_nxt = 8'd0;
    else if (dma_req && (r_starve != 8'(STARVE_LIMIT)))
      w_starve_nxt = r_starve + 8'd1;
    w_force_nxt = r_force + {3'b000, dma_gnt};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_CPU;
      r_starve <= 8'd0;
      r_force  <= 4'd0;
    end else if (r_state == S_CPU) begin
      r_starve <= w_starve_nxt;
      if (w_starve_nxt == 8'(STARVE_LIMIT)) begin
        r_state <= S_FORCE;
        r_force <= 4'd0;
      end
    end else begin
      if (!dma_req || (w_force_nxt == 4'(FORCE_LEN))) begin
        r_state  <= S_CPU;
        r_starve <= 8'd0;
        r_force  <= 4'd0;
      end else begin
        r_force <= w_force_nxt;
      end
    end
  end

  assign force_win = (r_state == S_FORCE);
  assign state     = r_state;

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the MEM-stage port and a DMA master.
// Define DMEM_ARB_STARVE_GUARD_EN to enable the DMA starvation guard.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned FORCE_LEN    = DEF_FORCE_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dbg_state
);

  // Handshake: a request is held until granted; dma_gnt (or !cpu_stall) in a
  // cycle means the access is performed at that cycle's rising edge.
  logic              w_cpu_acc;
  logic              w_force;
  logic              w_cpu_win;
  logic              w_dma_win;
  logic [ADDR_W-1:0] r_last_addr;
  logic [DATA_W-1:0] r_last_wdata;
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic              r_both_seen;

  assign w_cpu_acc = cpu_rd | cpu_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_guard #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .FORCE_LEN    (FORCE_LEN)
  ) u_guard (
    .clk       (clk),
    .reset     (reset),
    .dma_req   (dma_req),
    .dma_gnt   (w_dma_win),
    .force_win (w_force),
    .state     (dbg_state)
  );
`else
  assign w_force   = 1'b0;
  assign dbg_state = ARB_CPU;
`endif

  // Nothing is granted while reset is held, whatever the requesters drive.
  assign w_dma_win = reset & dma_req & (w_force | ~w_cpu_acc);
  assign w_cpu_win = reset & w_cpu_acc & ~w_dma_win;
  assign cpu_stall = reset & w_cpu_acc & ~w_cpu_win;
  assign dma_gnt   = w_dma_win;

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = r_last_addr;
    mem_wdata = r_last_wdata;
    if (w_cpu_win) begin
      mem_wr    = cpu_wr;
      mem_rd    = cpu_rd & ~cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dma_win) begin
      mem_wr    = dma_we;
      mem_rd    = ~dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_addr  <= '0;
      r_last_wdata <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWN_CPU;
      r_both_seen  <= 1'b0;
    end else begin
      if (w_cpu_win || w_dma_win) begin
        r_last_addr  <= mem_addr;
        r_last_wdata <= mem_wdata;
      end
      r_rd_pend  <= mem_rd;
      r_rd_owner <= w_dma_win ? OWN_DMA : OWN_CPU;
      if (cpu_rd && cpu_wr)
        r_both_seen <= 1'b1;
      // Simultaneous load+store is resolved as a store; flag it once.
      assert (!(cpu_rd && cpu_wr) || r_both_seen);
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = reset & r_rd_pend & (r_rd_owner == OWN_DMA);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a registered-read memory model.
// Guard-specific steps are selected by DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_gnt, dma_rvalid;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // clock block
  always #5 clk = ~clk;

  // memory macro model: registered read, write at the edge
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
  endtask

  initial begin
    mem[16] = 32'hDEADBEEF;  // 0x40
    mem[32] = 32'h12345678;  // 0x80
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();

    // reset state
    chk("rst_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rst_state", {31'b0, dbg_state}, 32'd0);
    reset = 1'b1;
    tick();

    // CPU load then store at 0x40
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    settle();
    chk("ld_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("ld_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_wdata = 32'hCAFE0001;
    settle();
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_no_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("st_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("st_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("st_wdata", mem_wdata, 32'hCAFE0001);
    chk("st_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("idle_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("idle_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("idle_hold_addr", mem_addr, 32'h40);
    chk("idle_hold_wdata", mem_wdata, 32'hCAFE0001);
    tick();

    // DMA read of 0x80 with CPU idle
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    settle();
    chk("dr_gnt", {31'b0, dma_gnt}, 32'd1);
    chk("dr_mem_rd", {31'b0, mem_rd}, 32'd1);
    chk("dr_addr", mem_addr, 32'h80);
    chk("dr_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    dma_req = 1'b0;
    settle();
    chk("dr_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("dr_rdata", dma_rdata, 32'h12345678);
    tick();
    chk("dr_rvalid_off", {31'b0, dma_rvalid}, 32'd0);

    // DMA write, then CPU read of the same word, then DMA read: no bubbles
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h84; dma_wdata = 32'h0000A5A5;
    settle();
    chk("dw_gnt", {31'b0, dma_gnt}, 32'd1);
    chk("dw_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("dw_wdata", mem_wdata, 32'h0000A5A5);
    tick();
    dma_req = 1'b0; dma_we = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 32'h84;
    settle();
    chk("dw_no_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("b2b_cpu_rd", {31'b0, mem_rd}, 32'd1);
    chk("b2b_cpu_addr", mem_addr, 32'h84);
    tick();
    cpu_rd = 1'b0;
    dma_req = 1'b1; dma_addr = 32'h80;
    settle();
    chk("b2b_cpu_rdata", cpu_rdata, 32'h0000A5A5);
    chk("b2b_cpu_no_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("b2b_dma_gnt", {31'b0, dma_gnt}, 32'd1);
    tick();
    dma_req = 1'b0;
    settle();
    chk("b2b_dma_rvalid", {31'b0, dma_rvalid}, 32'd1);
    chk("b2b_dma_rdata", dma_rdata, 32'h12345678);
    tick();

`ifdef DMEM_ARB_STARVE_GUARD_EN
    // contention: 8 CPU wins, 2 forced DMA grants, CPU resumes
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("st_deny%0d_gnt", i), {31'b0, dma_gnt}, 32'd0);
      chk($sformatf("st_deny%0d_stall", i), {31'b0, cpu_stall}, 32'd0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      settle();
      chk($sformatf("fw%0d_gnt", i), {31'b0, dma_gnt}, 32'd1);
      chk($sformatf("fw%0d_stall", i), {31'b0, cpu_stall}, 32'd1);
      chk($sformatf("fw%0d_state", i), {31'b0, dbg_state}, 32'd1);
      chk($sformatf("fw%0d_addr", i), mem_addr, 32'h80);
      tick();
    end
    settle();
    chk("fw_exit_state", {31'b0, dbg_state}, 32'd0);
    chk("fw_exit_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("fw_exit_stall", {31'b0, cpu_stall}, 32'd0);
    chk("fw_exit_addr", mem_addr, 32'h40);
    chk("fw_exit_rvalid", {31'b0, dma_rvalid}, 32'd1);

    // forced window cut short by a DMA drop after one grant
    for (int i = 0; i < 8; i++) begin
      settle();
      chk($sformatf("dp_deny%0d_gnt", i), {31'b0, dma_gnt}, 32'd0);
      tick();
    end
    settle();
    chk("dp_force_gnt", {31'b0, dma_gnt}, 32'd1);
    chk("dp_force_state", {31'b0, dbg_state}, 32'd1);
    tick();
    dma_req = 1'b0;
    settle();
    chk("dp_drop_state", {31'b0, dbg_state}, 32'd1);
    chk("dp_drop_stall", {31'b0, cpu_stall}, 32'd0);
    chk("dp_drop_cpu_rd", {31'b0, mem_rd}, 32'd1);
    chk("dp_drop_cpu_addr", mem_addr, 32'h40);
    chk("dp_drop_rvalid", {31'b0, dma_rvalid}, 32'd1);
    tick();
    chk("dp_after_state", {31'b0, dbg_state}, 32'd0);

    // limit reached in the same cycle the DMA is granted: no window
    dma_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      settle();
      chk($sformatf("sim_deny%0d_gnt", i), {31'b0, dma_gnt}, 32'd0);
      tick();
    end
    cpu_rd = 1'b0;
    settle();
    chk("sim_idle_gnt", {31'b0, dma_gnt}, 32'd1);
    tick();
    cpu_rd = 1'b1;
    settle();
    chk("sim_no_force_state", {31'b0, dbg_state}, 32'd0);
    chk("sim_no_force_gnt", {31'b0, dma_gnt}, 32'd0);
    chk("sim_no_force_stall", {31'b0, cpu_stall}, 32'd0);
    tick();
    idle_inputs();
    tick();
`else
    // strict priority: continuous contention never grants the DMA
    cpu_rd = 1'b1; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    for (int i = 0; i < 50; i++) begin
      settle();
      chk($sformatf("sp%0d_gnt", i), {31'b0, dma_gnt}, 32'd0);
      chk($sformatf("sp%0d_stall", i), {31'b0, cpu_stall}, 32'd0);
      tick();
    end
    idle_inputs();
    tick();
`endif

    // reset asserted with a DMA read in flight
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
    settle();
    chk("rf_gnt", {31'b0, dma_gnt}, 32'd1);
    tick();
    idle_inputs();
    reset = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 32'h44;
    settle();
    chk("rf_rvalid", {31'b0, dma_rvalid}, 32'd0);
    chk("rf_mem_rd", {31'b0, mem_rd}, 32'd0);
    chk("rf_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rf_gnt_off", {31'b0, dma_gnt}, 32'd0);
    tick();
    chk("rf_rvalid2", {31'b0, dma_rvalid}, 32'd0);
    chk("rf_mem_addr", mem_addr, 32'h0);
    chk("rf_mem_wdata", mem_wdata, 32'h0);
    chk("rf_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rf_state", {31'b0, dbg_state}, 32'd0);
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("rf_post_rvalid", {31'b0, dma_rvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
